// File: rtl/rf_wb_port_arbiter.sv
// Shares the register-file write port: pipeline writeback wins, MDU results queue in an in-order FIFO
// and retire in free cycles (one cycle after enqueue at the earliest); a starved head forces a one-cycle pipe_stall.
module rf_wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     p_we,
  input  logic [4:0]               p_rd,
  input  logic [31:0]              p_wd,
  input  logic                     m_valid,
  input  logic [4:0]               m_rd,
  input  logic [31:0]              m_wd,
  output logic                     m_ready,
  input  logic [4:0]               chk_rd,
  output logic                     chk_hit,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     pipe_stall,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, PEND, DRAIN} state_t;

  logic [4:0]    q_rd [DEPTH];
  logic [31:0]   q_wd [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_nxt;
  logic          p_req;
  logic          m_hs;
  logic          enq;
  logic          head_gnt;
  logic [PW-1:0] off;
  logic          hit;

  assign p_req    = p_we && (p_rd != 5'd0);
  // Ready looks only at registered occupancy, so a same-cycle dequeue never opens a slot early.
  assign m_ready  = (cnt != FULL);
  assign m_hs     = m_valid && m_ready;
  assign enq      = m_hs && (m_rd != 5'd0);
  assign head_gnt = (cnt != '0) && (pipe_stall || !p_req);
  assign cnt_nxt  = cnt + CW'(enq) - CW'(head_gnt);
  assign fifo_cnt = cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq)      wr_ptr <= wr_ptr + PW'(1);
      if (head_gnt) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[wr_ptr] <= m_rd;
      q_wd[wr_ptr] <= m_wd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    case (state)
      IDLE: begin
        starve_nxt = '0;
        if (cnt_nxt != '0) state_nxt = PEND;
      end
      PEND: begin
        if (head_gnt) begin
          starve_nxt = '0;
          state_nxt  = (cnt_nxt == '0) ? IDLE : PEND;
        end else begin
          starve_nxt = starve + SW'(1);
          if (starve_nxt == STARVE_LIM) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The head is always granted here, so leaving DRAIN is unconditional.
        starve_nxt = '0;
        state_nxt  = (cnt_nxt == '0) ? IDLE : PEND;
      end
      default: begin
        starve_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_comb begin
    pipe_stall = (state == DRAIN);
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (head_gnt) begin
      rf_we    = 1'b1;
      rf_waddr = q_rd[rd_ptr];
      rf_wdata = q_wd[rd_ptr];
    end else if (p_req) begin
      rf_we    = 1'b1;
      rf_waddr = p_rd;
      rf_wdata = p_wd;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < cnt) && (q_rd[i] == chk_rd)) hit = 1'b1;
    end
    if (m_hs && (m_rd == chk_rd)) hit = 1'b1;
    chk_hit = hit && (chk_rd != 5'd0);
  end

endmodule

// File: tb/tb_rf_wb_port_arbiter.sv
// Directed and random stimulus for rf_wb_port_arbiter against a queue-based reference model.
module tb_rf_wb_port_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     p_we;
  logic [4:0]               p_rd;
  logic [31:0]              p_wd;
  logic                     m_valid;
  logic [4:0]               m_rd;
  logic [31:0]              m_wd;
  logic                     m_ready;
  logic [4:0]               chk_rd;
  logic                     chk_hit;
  logic                     rf_we;
  logic [4:0]               rf_waddr;
  logic [31:0]              rf_wdata;
  logic                     pipe_stall;
  logic [$clog2(DEPTH):0]   fifo_cnt;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t q[$];
  int   starve = 0;
  bit   stall  = 0;
  bit   accepted;
  logic r_we, r_mv;
  logic [4:0] r_prd, r_mrd, r_crd;

  rf_wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .p_we(p_we), .p_rd(p_rd), .p_wd(p_wd),
    .m_valid(m_valid), .m_rd(m_rd), .m_wd(m_wd), .m_ready(m_ready),
    .chk_rd(chk_rd), .chk_hit(chk_hit),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: compares this cycle's outputs, then advances the queue to the post-edge state.
  task automatic model_cycle();
    bit   preq, gnt, e_ready, e_hit, e_we;
    int   n;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    n       = q.size();
    preq    = p_we && (p_rd != 0);
    e_ready = (n != DEPTH);
    gnt     = (n > 0) && (stall || !preq);
    e_we = 0; e_addr = 0; e_data = 0;
    if (gnt) begin
      e_we = 1; e_addr = q[0].rd; e_data = q[0].wd;
    end else if (preq) begin
      e_we = 1; e_addr = p_rd; e_data = p_wd;
    end
    e_hit = 0;
    foreach (q[i]) if (q[i].rd == chk_rd) e_hit = 1;
    if (m_valid && e_ready && m_rd == chk_rd) e_hit = 1;
    if (chk_rd == 0) e_hit = 0;

    check("rf_we",      rf_we,      e_we);
    check("rf_waddr",   rf_waddr,   e_addr);
    check("rf_wdata",   rf_wdata,   e_data);
    check("pipe_stall", pipe_stall, stall);
    check("m_ready",    m_ready,    e_ready);
    check("chk_hit",    chk_hit,    e_hit);
    check("fifo_cnt",   fifo_cnt,   n);

    if (gnt) begin
      void'(q.pop_front());
      starve = 0;
      stall  = 0;
    end else if (n > 0) begin
      starve++;
      stall = (starve == STARVE_MAX);
    end else begin
      stall = 0;
    end
    if (m_valid && e_ready && m_rd != 0) q.push_back('{rd: m_rd, wd: m_wd});
  endtask

  task automatic drive(input logic we, input logic [4:0] prd, input logic [31:0] pwd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                       input logic [4:0] crd);
    @(negedge clk);
    p_we = we; p_rd = prd; p_wd = pwd;
    m_valid = mv; m_rd = mrd; m_wd = mwd; chk_rd = crd;
    #1;
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rstn = 0; p_we = 0; p_rd = 0; p_wd = 0;
    m_valid = 0; m_rd = 0; m_wd = 0; chk_rd = 0;
    #1;
    check("rst_cnt",   fifo_cnt,   0);
    check("rst_ready", m_ready,    1);
    check("rst_we",    rf_we,      0);
    check("rst_addr",  rf_waddr,   0);
    check("rst_data",  rf_wdata,   0);
    check("rst_stall", pipe_stall, 0);
    check("rst_hit",   chk_hit,    0);
    @(negedge clk);
    rstn = 1;

    // Idle drain
    drive(0, 0, 0, 1, 5, 32'h1234, 0);
    check("idle_cnt_enq", fifo_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("idle_we",   rf_we,    1);
    check("idle_addr", rf_waddr, 5);
    check("idle_data", rf_wdata, 32'h1234);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("idle_cnt0", fifo_cnt, 0);

    // Priority
    drive(1, 3, 32'hA, 1, 7, 32'h77, 0);
    check("prio_p_addr", rf_waddr, 3);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("prio_m_addr", rf_waddr, 7);
    check("prio_m_data", rf_wdata, 32'h77);
    idle(2);

    // Starvation
    drive(0, 0, 0, 1, 9, 32'h99, 0);
    for (int i = 0; i < STARVE_MAX; i++) begin
      drive(1, 4, 32'h44, 0, 0, 0, 0);
      check("starve_deny_addr",  rf_waddr,   4);
      check("starve_deny_stall", pipe_stall, 0);
    end
    drive(1, 4, 32'h44, 0, 0, 0, 0);
    check("starve_stall", pipe_stall, 1);
    check("starve_addr",  rf_waddr,   9);
    drive(1, 4, 32'h44, 0, 0, 0, 0);
    check("starve_after_stall", pipe_stall, 0);
    check("starve_after_addr",  rf_waddr,   4);
    idle(2);

    // Full / backpressure
    drive(1, 4, 32'h44, 1, 10, 32'h10, 0);
    drive(1, 4, 32'h44, 1, 11, 32'h11, 0);
    drive(1, 4, 32'h44, 1, 12, 32'h12, 0);
    check("full_ready0", m_ready,  0);
    check("full_cnt2",   fifo_cnt, 2);
    accepted = 0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      drive(1, 4, 32'h44, 1, 12, 32'h12, 0);
      check("full_cnt_le2", fifo_cnt <= 2, 1);
      if (m_ready) accepted = 1;
    end
    check("full_third_accepted", accepted, 1);
    idle(6);

    // x0 handshake
    drive(0, 0, 0, 1, 0, 32'h55, 0);
    check("x0_ready", m_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("x0_cnt", fifo_cnt, 0);
    check("x0_we",  rf_we,    0);

    // Hazard and p_rd==0
    drive(1, 4, 32'h44, 1, 12, 32'hC, 12);
    check("hz_enq_hit", chk_hit, 1);
    drive(1, 4, 32'h44, 0, 0, 0, 12);
    check("hz_q_hit", chk_hit, 1);
    drive(1, 4, 32'h44, 0, 0, 0, 0);
    check("hz_x0_hit", chk_hit, 0);
    drive(1, 0, 32'hDEAD, 0, 0, 0, 0);
    check("prd0_we",   rf_we,    1);
    check("prd0_addr", rf_waddr, 12);
    check("prd0_data", rf_wdata, 32'hC);
    idle(3);

    // Reset mid-queue
    drive(1, 4, 32'h44, 1, 20, 32'h20, 0);
    drive(1, 4, 32'h44, 1, 21, 32'h21, 20);
    check("mq_cnt_pre", fifo_cnt, 1);
    @(negedge clk);
    p_we = 0; m_valid = 0; chk_rd = 20;
    #2 rstn = 0;
    #1;
    check("mq_rst_cnt",   fifo_cnt, 0);
    check("mq_rst_ready", m_ready,  1);
    check("mq_rst_we",    rf_we,    0);
    check("mq_rst_hit",   chk_hit,  0);
    q.delete();
    starve = 0;
    stall  = 0;
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 21);
      check("mq_no_stale", rf_we, 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r_we  = ($urandom_range(0, 3) != 0);
      r_prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r_mv  = ($urandom_range(0, 2) == 0);
      r_mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) r_crd = q[$urandom_range(0, q.size() - 1)].rd;
      else r_crd = 5'($urandom_range(0, 31));
      drive(r_we, r_prd, $urandom, r_mv, r_mrd, $urandom, r_crd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
